// File: rtl/eq_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : eq_i2s_tx
// Description : I2S transmitter for the equalizer output. It has a 2-entry
//               sample FIFO and generates BCLK/LRCLK from clk. Each mono
//               sample is sent on both the left and right slots.
//               Define EQ_I2S_LJ_EN to select left-justified data alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module eq_i2s_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  underrun
);

    localparam int c_DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int c_BIT_W = $clog2(2 * SLOT_WIDTH);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [c_BIT_W-1:0] c_SLOT     = c_BIT_W'(SLOT_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;
    logic [c_DIV_W-1:0]    r_div_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_bclk;
    logic                  r_lrclk;
    logic                  r_sdata;
    logic                  r_underrun;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_div_tc;
    logic                  w_fall;
    logic                  w_frame_start;
    logic [c_BIT_W-1:0]    w_bit_nxt;
    logic                  w_lr_nxt;
    logic [c_BIT_W-1:0]    w_k;
    logic [DATA_WIDTH-1:0] w_hold_nxt;
    logic                  w_sdata_nxt;

    assign w_full       = (r_count == 2'd2);
    assign w_empty      = (r_count == 2'd0);
    assign sample_ready = !w_full && !rst;
    assign w_push       = sample_valid && sample_ready;

    assign w_div_tc      = (r_div_cnt == c_DIV_LAST);
    assign w_fall        = w_div_tc && r_bclk;
    assign w_frame_start = w_fall && (r_bit_cnt == c_BIT_LAST);
    assign w_pop         = w_frame_start && !w_empty;

    // Serial outputs are computed from the post-event bit position and hold
    // value so the new frame's first bit is already correct at frame start.
    assign w_bit_nxt  = (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + c_BIT_W'(1);
    assign w_lr_nxt   = (w_bit_nxt >= c_SLOT);
    assign w_k        = w_lr_nxt ? (w_bit_nxt - c_SLOT) : w_bit_nxt;
    assign w_hold_nxt = !w_frame_start ? r_hold : (w_empty ? '0 : r_mem[r_rptr]);

    always_comb begin
        w_sdata_nxt = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
`ifdef EQ_I2S_LJ_EN
            if (w_k == c_BIT_W'(DATA_WIDTH - 1 - i)) w_sdata_nxt = w_hold_nxt[i];
`else
            if (w_k == c_BIT_W'(DATA_WIDTH - i)) w_sdata_nxt = w_hold_nxt[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= sample_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_hold     <= '0;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_frame_start && w_empty;
            r_div_cnt  <= w_div_tc ? '0 : r_div_cnt + c_DIV_W'(1);
            if (w_div_tc) r_bclk <= !r_bclk;
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrclk   <= w_lr_nxt;
                r_sdata   <= w_sdata_nxt;
            end
            if (w_frame_start) r_hold <= w_hold_nxt;
            if (w_push) r_wptr <= !r_wptr;
            if (w_pop)  r_rptr <= !r_rptr;
            if (w_push && !w_pop)      r_count <= r_count + 2'd1;
            else if (w_pop && !w_push) r_count <= r_count - 2'd1;
        end
    end

    assign bclk     = r_bclk;
    assign lrclk    = r_lrclk;
    assign sdata    = r_sdata;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_eq_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_eq_i2s_tx
// Description : Scoreboard bench for eq_i2s_tx (honours EQ_I2S_LJ_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eq_i2s_tx;

    localparam int DW    = 24;
    localparam int SW    = 32;
    localparam int DIV   = 4;
    localparam int FRAME = 4 * SW * DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          underrun;

    eq_i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: t counts clk edges since reset release.
    int            t = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_frames[$];
    logic          exp_und = 1'b0;
    logic          m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t = 0;
            fifo_q.delete();
            exp_frames.delete();
            exp_und = 1'b0;
        end else begin
            m_acc   = sample_valid && (fifo_q.size() < 2);
            t++;
            exp_und = 1'b0;
            if (t % FRAME == 0) begin
                if (fifo_q.size() > 0) exp_frames.push_back(fifo_q.pop_front());
                else begin
                    exp_frames.push_back('0);
                    exp_und = 1'b1;
                end
            end
            if (m_acc) fifo_q.push_back(sample_in);
        end
    end

    function automatic logic [SW-1:0] slot_of(input logic [DW-1:0] v);
        logic [SW-1:0] s;
        s = '0;
`ifdef EQ_I2S_LJ_EN
        s[SW-1 -: DW] = v;
`else
        s[SW-2 -: DW] = v;
`endif
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0d)", name, got, exp, t);
        end
    endtask

    // Monitor: per-cycle clock/flag checks plus frame deserialisation.
    logic          prev_bclk  = 1'b0;
    logic          prev_lr    = 1'b0;
    logic          active     = 1'b0;
    logic          seen_first = 1'b0;
    int            nbits      = 0;
    logic [DW-1:0] head;
    logic [2*SW-1:0] got_frame = '0;
    logic [2*SW-1:0] cur_exp   = '0;

    always @(negedge clk) begin
        check("bclk", bclk, ((t / DIV) % 2) == 1);
        check("lrclk", lrclk, ((t / (2 * DIV)) % (2 * SW)) >= SW);
        check("underrun", underrun, exp_und);
        check("ready", sample_ready, !rst && (fifo_q.size() < 2));
        if (rst) begin
            active     = 1'b0;
            seen_first = 1'b0;
            prev_bclk  = 1'b0;
            prev_lr    = 1'b0;
        end else begin
            if (prev_bclk && !bclk) begin
                if (prev_lr && !lrclk) begin
                    seen_first = 1'b1;
                    if (exp_frames.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL frame_start: got=unexpected frame expected=none queued (t=%0d)", t);
                    end else begin
                        head    = exp_frames.pop_front();
                        cur_exp = {slot_of(head), slot_of(head)};
                        active  = 1'b1;
                        nbits   = 0;
                    end
                end
                if (!seen_first) check("idle_sdata", sdata, 1'b0);
                if (active) begin
                    got_frame[2*SW-1-nbits] = sdata;
                    nbits++;
                    if (nbits == 2 * SW) begin
                        check("frame", got_frame, cur_exp);
                        active = 1'b0;
                    end
                end
            end
            prev_bclk = bclk;
            prev_lr   = lrclk;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [DW-1:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        step(1);
        sample_valid = 1'b0;
    endtask

    initial begin
        // Idle link: silence frames with periodic underrun.
        do_reset();
        step(2 * FRAME + 20);

        // Single sample ahead of the first frame start.
        do_reset();
        step(10);
        push_one(24'h800001);
        step(2 * FRAME + 20);

        // Fill the FIFO; a third valid while full is dropped.
        do_reset();
        step(5);
        sample_valid = 1'b1;
        sample_in = 24'h123456; step(1);
        sample_in = 24'hABCDEF; step(1);
        sample_in = 24'h777777; step(1);
        sample_valid = 1'b0;
        step(3 * FRAME + 20);

        // Valid held high across several frame starts.
        for (int i = 0; i < 4 * FRAME; i++) begin
            sample_in    = DW'($urandom);
            sample_valid = 1'b1;
            step(1);
        end
        sample_valid = 1'b0;
        step(2 * FRAME + 20);

        // Reset mid-frame at bit 40 with one sample queued.
        do_reset();
        step(3);
        push_one(24'h5A5A5A);
        for (int i = 0; i < 2000 && t <= FRAME; i++) step(1);
        push_one(24'h3C3C3C);
        for (int i = 0; i < 2000 && t < FRAME + 40 * 2 * DIV; i++) step(1);
        #2 rst = 1'b1;
        #1;
        check("rst_bclk", bclk, 1'b0);
        check("rst_lrclk", lrclk, 1'b0);
        check("rst_sdata", sdata, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_ready", sample_ready, 1'b0);
        step(2);
        rst = 1'b0;
        step(2 * FRAME + 20);

        // Sparse random traffic.
        do_reset();
        for (int i = 0; i < 5 * FRAME; i++) begin
            sample_in    = DW'($urandom);
            sample_valid = ($urandom_range(0, 63) == 0);
            step(1);
        end
        sample_valid = 1'b0;
        step(2 * FRAME + 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
